// File: rtl/sos_sample_pacer_if.sv
// Sample-side and strobe-side signals of the SOS sample pacer.
// The master drives samples and hold. The slave is the pacer, which returns ready, the strobe and the occupancy.
interface sos_sample_pacer_if #(
    parameter int Ndint  = 3,
    parameter int Ndfrac = 22,
    parameter int DEPTH  = 8
);
    localparam int W  = Ndint + Ndfrac;
    localparam int LW = $clog2(DEPTH) + 1;

    logic          s_valid;
    logic [W-1:0]  s_data;
    logic          s_ready;
    logic          hold;
    logic          dv_out;
    logic [W-1:0]  d_out;
    logic [LW-1:0] level;

    modport master (
        output s_valid, s_data, hold,
        input  s_ready, dv_out, d_out, level
    );

    modport slave (
        input  s_valid, s_data, hold,
        output s_ready, dv_out, d_out, level
    );
endinterface

// File: rtl/sos_sample_pacer.sv
// Buffers bursty Q(Ndint).(Ndfrac) samples and re-emits them as single-cycle strobes
// spaced at least GAP cycles apart, so a multi-cycle MAC section can keep up.
module sos_sample_pacer #(
    parameter int Ndint  = 3,
    parameter int Ndfrac = 22,
    parameter int DEPTH  = 8,
    parameter int GAP    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    sos_sample_pacer_if.slave bus
);
    localparam int W  = Ndint + Ndfrac;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [LW-1:0] FULL       = LW'(DEPTH);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [GW-1:0] gap_cnt;
    logic          dv_q;
    logic [W-1:0]  d_q;
    logic          push;
    logic          pop;

    // Ready comes from the registered level only, so a pop cannot free a slot for the same cycle's write.
    assign bus.s_ready = (level_q != FULL);

    // NOTE: each combinational output gets a default at the top of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        push = 1'b0;
        pop  = 1'b0;
        if (bus.s_valid && bus.s_ready) push = 1'b1;
        if ((level_q != '0) && (gap_cnt == '0) && !bus.hold) pop = 1'b1;
    end

    // NOTE: the sample storage has no reset. Stale words are unreachable because level gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.s_data;
    end

    // NOTE: all state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // The gap counter keeps running under hold, so a release after a long hold emits at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (pop) begin
            gap_cnt <= GAP_RELOAD;
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q <= 1'b0;
            d_q  <= '0;
        end else begin
            dv_q <= pop;
            if (pop) d_q <= mem[rd_ptr];
        end
    end

    assign bus.dv_out = dv_q;
    assign bus.d_out  = d_q;
    assign bus.level  = level_q;

    a_level_bound: assert property (@(posedge clk) disable iff (!rst_n) level_q <= FULL);

    if (GAP > 1) begin : g_strobe_shape
        a_single_strobe: assert property (@(posedge clk) disable iff (!rst_n) dv_q |=> !dv_q);
    end
endmodule

// File: tb/tb_sos_sample_pacer.sv
// Directed bench for sos_sample_pacer. It combines a per-cycle vector table, hand-written corner sequences,
// and a scoreboard-driven collector that checks strobe data and spacing.
module tb_sos_sample_pacer;
    localparam int Ndint  = 3;
    localparam int Ndfrac = 22;
    localparam int DEPTH  = 8;
    localparam int GAP    = 6;
    localparam int W      = Ndint + Ndfrac;
    localparam int LW     = $clog2(DEPTH) + 1;

    localparam logic [W-1:0] S_A = 25'h0400000;  //  1.0
    localparam logic [W-1:0] S_B = 25'h0200000;  //  0.5
    localparam logic [W-1:0] S_C = 25'h1E00000;  // -0.5

    typedef struct {
        logic          s_valid;
        logic [W-1:0]  s_data;
        logic          hold;
        logic          exp_dv;
        logic [W-1:0]  exp_d;
        logic [LW-1:0] exp_level;
        logic          exp_ready;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    vec_t vecs [13];
    logic [W-1:0] exp_q [$];

    sos_sample_pacer_if #(.Ndint(Ndint), .Ndfrac(Ndfrac), .DEPTH(DEPTH)) bus ();

    sos_sample_pacer #(
        .Ndint (Ndint),
        .Ndfrac(Ndfrac),
        .DEPTH (DEPTH),
        .GAP   (GAP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic h,
                                input logic edv, input logic [W-1:0] ed, input int elvl);
        vec_t r;
        r.s_valid   = v;
        r.s_data    = d;
        r.hold      = h;
        r.exp_dv    = edv;
        r.exp_d     = ed;
        r.exp_level = LW'(elvl);
        r.exp_ready = 1'b1;
        return r;
    endfunction

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            bus.s_valid = vecs[i].s_valid;
            bus.s_data  = vecs[i].s_data;
            bus.hold    = vecs[i].hold;
            tick();
            check($sformatf("vec%0d_dv", i),    bus.dv_out,  vecs[i].exp_dv);
            check($sformatf("vec%0d_d", i),     bus.d_out,   vecs[i].exp_d);
            check($sformatf("vec%0d_level", i), bus.level,   vecs[i].exp_level);
            check($sformatf("vec%0d_ready", i), bus.s_ready, vecs[i].exp_ready);
        end
        bus.s_valid = 1'b0;
        bus.hold    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Offer every queued sample in order, waiting on s_ready with a bounded budget.
    task automatic push_all();
        foreach (exp_q[i]) begin
            logic acc;
            int   waited;
            acc    = 1'b0;
            waited = 0;
            bus.s_valid = 1'b1;
            bus.s_data  = exp_q[i];
            while (!acc && waited < 200) begin
                acc = bus.s_ready;
                tick();
                waited++;
            end
            check($sformatf("push%0d_accepted", i), acc, 1'b1);
        end
        bus.s_valid = 1'b0;
    endtask

    // Scoreboard: strobes must carry exp_q in order, GAP apart, with d_out stable in between.
    task automatic collect(input string tag, input int budget);
        int got;
        int cyc;
        int last;
        logic [W-1:0] held;
        got  = 0;
        cyc  = 0;
        last = -1;
        held = bus.d_out;
        while (got < exp_q.size() && cyc < budget) begin
            tick();
            cyc++;
            if (bus.dv_out) begin
                check($sformatf("%s_data%0d", tag, got), bus.d_out, exp_q[got]);
                if (last >= 0) check($sformatf("%s_gap%0d", tag, got), cyc - last, GAP);
                last = cyc;
                held = bus.d_out;
                got++;
            end else begin
                check($sformatf("%s_hold_d", tag), bus.d_out, held);
            end
        end
        check($sformatf("%s_strobe_count", tag), got, exp_q.size());
        tick();
        check($sformatf("%s_end_dv", tag), bus.dv_out, 1'b0);
        check($sformatf("%s_end_level", tag), bus.level, 0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.hold    = 1'b0;

        // Single sample, then a hold-decrement sequence. B is held for a while, C waits out the gap under hold.
        vecs[0]  = mk(1'b1, S_A, 1'b0, 1'b0, '0,  1);
        vecs[1]  = mk(1'b0, '0,  1'b0, 1'b1, S_A, 0);
        vecs[2]  = mk(1'b0, '0,  1'b0, 1'b0, S_A, 0);
        vecs[3]  = mk(1'b0, '0,  1'b0, 1'b0, S_A, 0);
        vecs[4]  = mk(1'b1, S_B, 1'b1, 1'b0, S_A, 1);
        vecs[5]  = mk(1'b0, '0,  1'b1, 1'b0, S_A, 1);
        vecs[6]  = mk(1'b0, '0,  1'b0, 1'b1, S_B, 0);
        vecs[7]  = mk(1'b1, S_C, 1'b0, 1'b0, S_B, 1);
        vecs[8]  = mk(1'b0, '0,  1'b1, 1'b0, S_B, 1);
        vecs[9]  = mk(1'b0, '0,  1'b1, 1'b0, S_B, 1);
        vecs[10] = mk(1'b0, '0,  1'b1, 1'b0, S_B, 1);
        vecs[11] = mk(1'b0, '0,  1'b1, 1'b0, S_B, 1);
        vecs[12] = mk(1'b0, '0,  1'b0, 1'b1, S_C, 0);

        // Reset with random activity on the inputs.
        for (int i = 0; i < 5; i++) begin
            bus.s_valid = 1'($urandom);
            bus.s_data  = W'($urandom);
            tick();
            check("rst_dv",    bus.dv_out,  1'b0);
            check("rst_d",     bus.d_out,   '0);
            check("rst_level", bus.level,   0);
            check("rst_ready", bus.s_ready, 1'b1);
        end
        bus.s_valid = 1'b0;
        rst_n       = 1'b1;
        idle(2);

        // Single sample, with d_out still holding it twenty cycles later.
        run_table(0, 4);
        idle(20);
        check("single_d_after_20", bus.d_out, S_A);
        run_table(4, 13);

        // Fill under hold: 1..8 accepted, 9 stalls, then drain in order.
        bus.hold = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = W'(n);
            check($sformatf("fill_ready%0d", n), bus.s_ready, 1'b1);
            tick();
        end
        bus.s_data = W'(9);
        check("fill_level",   bus.level,   DEPTH);
        check("fill_ready9",  bus.s_ready, 1'b0);
        check("fill_dv",      bus.dv_out,  1'b0);
        idle(2);
        check("fill_stalled", bus.level,   DEPTH);
        exp_q.delete();
        for (int n = 1; n <= 9; n++) exp_q.push_back(W'(n));
        bus.hold = 1'b0;
        fork
            collect("drain", 120);
            begin
                tick();
                check("drain_first_ready", bus.s_ready, 1'b1);
                check("drain_first_level", bus.level,   DEPTH - 1);
                tick();
                bus.s_valid = 1'b0;
                check("drain_push9_level", bus.level,   DEPTH);
            end
        join
        idle(GAP);

        // Continuous stream of 40 samples.
        exp_q.delete();
        for (int i = 0; i < 40; i++) exp_q.push_back(W'(32'h0013579 * (i + 1)));
        fork
            push_all();
            collect("stream", 40 * GAP + 50);
        join
        idle(GAP);

        // Pointer wrap with negative values.
        exp_q.delete();
        for (int i = 0; i < 20; i++) exp_q.push_back((i % 2 == 0) ? 25'h1FFFFFF : 25'h1000000);
        fork
            push_all();
            collect("wrap", 20 * GAP + 50);
        join
        idle(GAP);

        // Mid-operation reset at level 5, mid-gap.
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(W'(32'h0100000 + i));
        push_all();
        check("mid_level_before", bus.level, 5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_level", bus.level,   0);
        check("mid_rst_dv",    bus.dv_out,  1'b0);
        check("mid_rst_ready", bus.s_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("mid_no_stale_dv", bus.dv_out, 1'b0);
        end
        check("mid_level_after", bus.level, 0);
        run_table(0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sos_sample_pacer.md
# sos_sample_pacer

Upstream feeder for the second-order-section filter chain. It accepts bursty samples on a valid/ready interface, buffers them in a small FIFO, and re-emits them as single-cycle `dv_out` strobes spaced at least `GAP` cycles apart. A multi-cycle MAC section needs that spacing because it only accepts a new sample after finishing its accumulate cycles. Data is signed fixed-point Q`Ndint`.`Ndfrac`, passed through unmodified.

## Interface
- `Ndint`, 3: integer bits of the data word, including the sign bit.
- `Ndfrac`, 22: fractional bits of the data word.
- `DEPTH`, 8: FIFO depth in samples. Power of two, ≥2.
- `GAP`, 6: minimum number of cycles between successive `dv_out` rising edges. ≥1; a value of 1 allows back-to-back strobes.

- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  upstream sample valid.
- `s_data`  in  `Ndint+Ndfrac`  upstream sample.
- `s_ready`  out  1  FIFO not full; a transfer occurs when `s_valid && s_ready`.
- `hold`  in  1  when high, no new strobes are issued; the FIFO keeps filling.
- `dv_out`  out  1  single-cycle strobe to the filter's `dv_in`.
- `d_out`  out  `Ndint+Ndfrac`  sample presented with `dv_out`; holds its value between strobes.
- `level`  out  `$clog2(DEPTH)+1`  current FIFO occupancy, 0..`DEPTH`.

## Operation
- **Reset (asynchronous, while `rst_n` = 0):**
  - `dv_out`=0, `d_out`=0, `level`=0.
  - Read/write pointers = 0; gap counter = 0.
  - `s_ready`=1, since it is combinational from `level`.
  - Any buffered contents are discarded.
- **Write:** on an edge with `s_valid && s_ready`:
  - `s_data` is stored at the write pointer.
  - The write pointer increments, modulo `DEPTH`.
- **`s_ready`:** equals `level != DEPTH`.
  - It uses the registered `level`.
  - A pop in the same cycle does not free a slot for that cycle's write, so a full FIFO stalls for one cycle even while draining.
- **Pop / emit:** on an edge where `level != 0`, gap counter == 0 and `hold` == 0:
  - `dv_out` <= 1 and `d_out` <= head entry.
  - The read pointer increments, modulo `DEPTH`.
  - The gap counter <= `GAP-1`.
- **Otherwise:**
  - `dv_out` <= 0.
  - `d_out` holds its value.
  - The gap counter decrements if nonzero.
- **Hold:** the gap counter keeps decrementing while `hold` is high. On release with the counter at 0, the emit happens on the first edge after release.
- **Simultaneous push and pop:** `level` is unchanged. If `level` was 0, the incoming sample is not eligible for emission in that cycle: there is no fall-through.
- **Pointer wrap:** wrap is silent. FIFO order is strictly preserved, and `level` alone distinguishes full from empty.
- **Overflow and underflow are impossible by construction:**
  - No write occurs when `level` == `DEPTH`.
  - No pop occurs when `level` == 0.

## Timing
- **Latency:** a sample written at edge k into an empty FIFO with the gap counter at 0 and `hold` low produces `dv_out`=1 in the cycle after edge k+1. That is one cycle of buffer latency.
- **Strobe spacing:** successive `dv_out` pulses are exactly `GAP` cycles apart while the FIFO stays non-empty and `hold` is low, and never fewer than `GAP` cycles apart.
- **Strobe shape:** `dv_out` is high for exactly one cycle per sample.
- **Data stability:** `d_out` is registered and stable for the whole interval from one strobe to the next.
- **`level`:** updates on the edge of each push or pop; its net change per edge is +1, 0 or −1.
- **Mid-operation reset:** asserting `rst_n` mid-operation clears everything immediately. The first accepted write after release behaves as from cold reset.

## Test plan
1. **Reset:**
   - Stimulus: hold `rst_n` low with random `s_valid`/`s_data`.
   - Required: `dv_out`=0, `d_out`=0, `level`=0, `s_ready`=1 throughout.
2. **Single sample:**
   - Stimulus: push 0x0400000 (1.0 in Q3.22) once.
   - Required: one `dv_out` pulse with `d_out`=0x0400000, in the cycle after the write edge plus one. `level` returns to 0. `d_out` still reads 0x0400000 20 cycles later.
3. **Fill under hold:**
   - Stimulus: `hold`=1 while offering samples 1..9 back to back.
   - Required during fill: samples 1..8 are accepted, `level`=8 and `s_ready`=0 with sample 9 stalled.
   - Required after `hold`=0: strobes carry 1..9 in order, exactly 6 cycles apart. `s_ready` returns to 1 on the edge after the first pop.
4. **Continuous stream:**
   - Stimulus: `s_valid` held high for 40 samples.
   - Required: every `dv_out` interval is 6 cycles and no sample is lost or duplicated. This is checked against a scoreboard.
5. **Wrap and sign:**
   - Stimulus: pass 20 samples alternating 0x1FFFFFF (−1 LSB) and 0x1000000 (−4.0) through `DEPTH`=8.
   - Required: output order and values are identical to the input across pointer wrap.
6. **Mid-operation reset:**
   - Stimulus: reach `level`=5 mid-gap, then pulse `rst_n` low for 1 cycle.
   - Required: `level`=0 and `dv_out`=0 immediately, with no stale strobes afterwards. A fresh push after release appears after the single-sample latency of scenario 2.
